// File: rtl/sm_addsub_pipe_pkg.sv
// Shared definitions for the pipelined sign-magnitude adder/subtractor.
// Holds the default width, the op encoding and the -0 folding helper.
package sm_addsub_pipe_pkg;

    localparam int SM_N_DEF = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } sm_op_e;

    // SM zero fix: a zero magnitude always carries a positive sign.
    function automatic logic sm_zero_fix_sign(input logic sign, input logic mag_is_zero);
        return sign & ~mag_is_zero;
    endfunction

endpackage

// File: rtl/sm_addsub_pipe_if.sv
// Valid/ready operand and result bundle for sm_addsub_pipe.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface sm_addsub_pipe_if #(parameter int N = 4);

    logic         in_valid;
    logic         in_ready;
    logic [N:0]   a;
    logic [N:0]   b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   sum;
    logic         ovflw;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovflw
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovflw
    );

endinterface

// File: rtl/sm_addsub_pipe_mag_order.sv
// Combinational magnitude compare/swap: larger magnitude on o_big, A wins ties.
module sm_mag_order #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_mag_a,
    input  logic [N-1:0] i_mag_b,
    output logic [N-1:0] o_big,
    output logic [N-1:0] o_small,
    output logic         o_a_ge_b
);

    assign o_a_ge_b = (i_mag_a >= i_mag_b);
    assign o_big    = o_a_ge_b ? i_mag_a : i_mag_b;
    assign o_small  = o_a_ge_b ? i_mag_b : i_mag_a;

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude add/sub with valid/ready back-pressure; never emits -0.
// Define SM_ADDSUB_SAT_EN to saturate the magnitude on overflow instead of wrapping.
module sm_addsub_pipe
    import sm_addsub_pipe_pkg::*;
#(
    parameter int N = SM_N_DEF
) (
    input logic             clk,
    input logic             reset_n,
    sm_addsub_pipe_if.slave bus
);

    logic [N:0]   w_a;
    logic [N:0]   w_b;
    logic         w_bs;
    logic         w_eff_sub;
    logic [N-1:0] w_big;
    logic [N-1:0] w_small;
    logic         w_a_ge_b;
    logic         w_adv;
    logic         w_in_ready;

    logic         r_s1_valid;
    logic [N-1:0] r_s1_big;
    logic [N-1:0] r_s1_small;
    logic         r_s1_eff_sub;
    logic         r_s1_sign_big;
    logic         r_s1_sign_a;

    logic         r_out_valid;
    logic [N:0]   r_sum;
    logic         r_ovflw;

    logic [N:0]   w_add;
    logic [N-1:0] w_diff;
    logic [N-1:0] w_mag;
    logic         w_sign;
    logic         w_ov;
    logic [N:0]   w_sum;

    // Fold -0 operands to +0 before any sign arithmetic.
    assign w_a = {sm_zero_fix_sign(bus.a[N], bus.a[N-1:0] == '0), bus.a[N-1:0]};
    assign w_b = {sm_zero_fix_sign(bus.b[N], bus.b[N-1:0] == '0), bus.b[N-1:0]};

    assign w_bs      = w_b[N] ^ (bus.sub == OP_SUB);
    assign w_eff_sub = w_a[N] ^ w_bs;

    sm_mag_order #(.N(N)) u_mag_order (
        .i_mag_a  (w_a[N-1:0]),
        .i_mag_b  (w_b[N-1:0]),
        .o_big    (w_big),
        .o_small  (w_small),
        .o_a_ge_b (w_a_ge_b)
    );

    assign w_adv      = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_big      <= '0;
            r_s1_small    <= '0;
            r_s1_eff_sub  <= 1'b0;
            r_s1_sign_big <= 1'b0;
            r_s1_sign_a   <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_big      <= w_big;
                r_s1_small    <= w_small;
                r_s1_eff_sub  <= w_eff_sub;
                r_s1_sign_big <= w_a_ge_b ? w_a[N] : w_bs;
                r_s1_sign_a   <= w_a[N];
            end
        end
    end

    assign w_add  = {1'b0, r_s1_big} + {1'b0, r_s1_small};
    assign w_diff = r_s1_big - r_s1_small;

    always_comb begin
        w_ov   = !r_s1_eff_sub && w_add[N];
        w_mag  = r_s1_eff_sub ? w_diff : w_add[N-1:0];
        w_sign = r_s1_eff_sub ? r_s1_sign_big : r_s1_sign_a;
`ifdef SM_ADDSUB_SAT_EN
        if (w_ov) begin
            w_mag = '1;
        end
`endif
        w_sum = {sm_zero_fix_sign(w_sign, w_mag == '0), w_mag};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_ovflw     <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum   <= w_sum;
                r_ovflw <= w_ov;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.ovflw     = r_ovflw;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed and exhaustive checks for sm_addsub_pipe at N=4 (both SM_ADDSUB_SAT_EN builds).
module tb_sm_addsub_pipe;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sm_addsub_pipe_if #(.N(4)) bus ();

    sm_addsub_pipe #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [4:0] va [0:2047];
    logic [4:0] vb [0:2047];
    logic       vs [0:2047];
    logic [4:0] got_sum [0:2047];
    logic       got_ov  [0:2047];
    int         pop_cyc [0:2047];
    int         str_popped;
    int         str_stall_pushes;
    logic       str_ready_end_stall;
    int         str_unstable;

`ifdef SM_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Behavioural SM reference returning {ovflw, sign, mag}.
    function automatic logic [5:0] model(input logic [4:0] a, input logic [4:0] b, input logic s);
        int x, y, r, mag;
        logic ov, sg;
        x = int'(a[3:0]); if (a[4]) x = -x;
        y = int'(b[3:0]); if (b[4]) y = -y;
        r = s ? x - y : x + y;
        mag = (r < 0) ? -r : r;
        ov = (mag > 15);
        if (ov) mag = SAT ? 15 : (mag % 16);
        sg = (r < 0) && (mag != 0);
        return {ov, sg, mag[3:0]};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic run_one(input logic [4:0] a, input logic [4:0] b, input logic s,
                           output logic [4:0] sum, output logic ov, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = s;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        sum = bus.sum;
        ov  = bus.ovflw;
    endtask

    task automatic stream(input int n, input int stall);
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic [4:0] held = '0;
        bit have_held = 0;
        str_stall_pushes = 0;
        str_unstable = 0;
        str_ready_end_stall = 1'b1;
        while (popped < n && cyc < n * 4 + 50) begin
            @(negedge clk);
            bus.out_ready = (cyc >= stall);
            if (pushed < n) begin
                bus.in_valid = 1'b1;
                bus.a = va[pushed]; bus.b = vb[pushed]; bus.sub = vs[pushed];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == stall - 1) str_ready_end_stall = bus.in_ready;
            if (cyc < stall && bus.out_valid) begin
                if (have_held && bus.sum !== held) str_unstable++;
                held = bus.sum;
                have_held = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                got_sum[popped] = bus.sum;
                got_ov[popped]  = bus.ovflw;
                pop_cyc[popped] = cyc;
                popped++;
            end
            if (bus.in_valid && bus.in_ready) begin
                pushed++;
                if (cyc < stall) str_stall_pushes++;
            end
            cyc++;
        end
        @(negedge clk);
        idle();
        str_popped = popped;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 5'h00 || bus.ovflw !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b sum=%h ovflw=%b, want 0 00 0",
                     bus.out_valid, bus.sum, bus.ovflw);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [4:0] s; logic o; int l;
        run_one(5'h05, 5'h03, 1'b0, s, o, l);
        checks++;
        if (s !== 5'h08 || o !== 1'b0) begin
            errors++; $display("FAIL add_5_3: sum=%h ov=%b want 08 0", s, o);
        end
        checks++;
        if (l !== 2) begin
            errors++; $display("FAIL latency: got %0d want 2", l);
        end
        run_one(5'h03, 5'h05, 1'b1, s, o, l);
        checks++;
        if (s !== 5'h12 || o !== 1'b0) begin
            errors++; $display("FAIL sub_3_5: sum=%h ov=%b want 12 0", s, o);
        end
        run_one(5'h16, 5'h06, 1'b0, s, o, l);
        checks++;
        if (s !== 5'h00 || o !== 1'b0) begin
            errors++; $display("FAIL neg6_plus6: sum=%h ov=%b want 00 0", s, o);
        end
        run_one(5'h10, 5'h10, 1'b0, s, o, l);
        checks++;
        if (s !== 5'h00 || o !== 1'b0) begin
            errors++; $display("FAIL negzero_sum: sum=%h ov=%b want 00 0", s, o);
        end
        run_one(5'h10, 5'h03, 1'b1, s, o, l);
        checks++;
        if (s !== 5'h13 || o !== 1'b0) begin
            errors++; $display("FAIL negzero_minus3: sum=%h ov=%b want 13 0", s, o);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] s; logic o; int l;
        run_one(5'h09, 5'h09, 1'b0, s, o, l);
        checks++;
        if (s !== (SAT ? 5'h0F : 5'h02) || o !== 1'b1) begin
            errors++; $display("FAIL ovf_9_9: sum=%h ov=%b want %h 1", s, o, SAT ? 5'h0F : 5'h02);
        end
        run_one(5'h1C, 5'h07, 1'b1, s, o, l);
        checks++;
        if (s !== (SAT ? 5'h1F : 5'h13) || o !== 1'b1) begin
            errors++; $display("FAIL ovf_m12_m7: sum=%h ov=%b want %h 1", s, o, SAT ? 5'h1F : 5'h13);
        end
        run_one(5'h18, 5'h08, 1'b1, s, o, l);
        checks++;
        if (s !== (SAT ? 5'h1F : 5'h00) || o !== 1'b1) begin
            errors++; $display("FAIL ovf_wrap_zero: sum=%h ov=%b want %h 1", s, o, SAT ? 5'h1F : 5'h00);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) begin
            va[i] = 5'(i + 1); vb[i] = 5'h00; vs[i] = 1'b0;
        end
        stream(4, 4);
        checks++;
        if (str_stall_pushes !== 2 || str_ready_end_stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: accepts=%0d in_ready=%b want 2 0", str_stall_pushes, str_ready_end_stall);
        end
        checks++;
        if (str_unstable !== 0) begin
            errors++; $display("FAIL bp_stable: sum changed %0d times while stalled, want 0", str_unstable);
        end
        checks++;
        if (str_popped !== 4) begin
            errors++; $display("FAIL bp_count: got %0d results want 4", str_popped);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < str_popped && (got_sum[i] !== 5'(i + 1) || got_ov[i] !== 1'b0)) begin
                errors++; $display("FAIL bp_order[%0d]: sum=%h want %h", i, got_sum[i], 5'(i + 1));
            end else if (i >= str_popped) begin
                errors++; $display("FAIL bp_order[%0d]: result missing", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            va[i] = 5'(i); vb[i] = 5'h01; vs[i] = 1'b0;
        end
        stream(8, 0);
        checks++;
        if (str_popped !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d want 8", str_popped);
        end else if (pop_cyc[7] - pop_cyc[0] !== 7 || pop_cyc[0] !== 2) begin
            errors++;
            $display("FAIL b2b_bubbles: first=%0d span=%0d want 2 7", pop_cyc[0], pop_cyc[7] - pop_cyc[0]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_sum[i] !== 5'(i + 1)) begin
                errors++; $display("FAIL b2b_val[%0d]: sum=%h want %h", i, got_sum[i], 5'(i + 1));
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [4:0] s; logic o; int l;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.a = 5'h0F; bus.b = 5'h01; bus.sub = 1'b0;
        @(negedge clk);
        bus.a = 5'h02; bus.b = 5'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full: out_valid=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 5'h00 || bus.ovflw !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: out_valid=%b sum=%h ovflw=%b want 0 00 0", bus.out_valid, bus.sum, bus.ovflw);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_flushed: out_valid=%b want 0", bus.out_valid);
        end
        run_one(5'h07, 5'h01, 1'b0, s, o, l);
        checks++;
        if (s !== 5'h08 || l !== 2) begin
            errors++; $display("FAIL mid_first: sum=%h lat=%0d want 08 2", s, l);
        end
    endtask

    task automatic test_sweep();
        logic [5:0] e;
        for (int i = 0; i < 2048; i++) begin
            va[i] = 5'(i % 32); vb[i] = 5'((i / 32) % 32); vs[i] = (i >= 1024);
        end
        stream(2048, 0);
        checks++;
        if (str_popped !== 2048) begin
            errors++; $display("FAIL sweep_count: got %0d want 2048", str_popped);
        end
        for (int i = 0; i < str_popped; i++) begin
            e = model(va[i], vb[i], vs[i]);
            checks++;
            if (got_sum[i] !== e[4:0] || got_ov[i] !== e[5]) begin
                errors++;
                $display("FAIL sweep a=%h b=%h sub=%b: sum=%h ov=%b want %h %b",
                         va[i], vb[i], vs[i], got_sum[i], got_ov[i], e[4:0], e[5]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_pressure();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
